// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline stall/flush/freeze controller.
package pipe_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t RUN    = 2'd0;
  localparam state_t FLUSH  = 2'd1;
  localparam state_t FREEZE = 2'd2;

  localparam int FLUSH_W = 3;
  localparam int WAIT_W  = 8;
  localparam int PERF_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/freeze sequencer driving the 5-stage pipeline register enables.
// Define PIPE_CTRL_PERF_EN to build the STALL/FLUSH/FREEZE performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              HAZ_NOP,
  input  logic              BR_TAKEN,
  input  logic              MEM_BUSY,
  input  logic              PERF_CLR,
  output logic              IF_LE,
  output logic              ID_LE,
  output logic              EX_LE,
  output logic              MEM_LE,
  output logic              ID_NOP,
  output logic              IFID_CLR,
  output logic              MEM_TO,
  output logic [PERF_W-1:0] STALL_CNT,
  output logic [PERF_W-1:0] FLUSH_CNT,
  output logic [PERF_W-1:0] FREEZE_CNT
);

  localparam logic [FLUSH_W-1:0] DEPTH    = FLUSH_W'(FLUSH_DEPTH);
  localparam logic [FLUSH_W-1:0] DEPTH_M1 = FLUSH_W'(FLUSH_DEPTH - 1);
  localparam logic [WAIT_W-1:0]  TO_M1    = WAIT_W'(MEM_TIMEOUT - 1);

  state_t               state_reg, state_next;
  logic [FLUSH_W-1:0]   flush_reg, flush_next;
  logic                 pend_reg, pend_next;
  logic [WAIT_W-1:0]    wait_cnt;

  always_comb begin
    state_next = state_reg;
    flush_next = flush_reg;
    pend_next  = pend_reg;
    IF_LE      = 1'b1;
    ID_LE      = 1'b1;
    EX_LE      = 1'b1;
    MEM_LE     = 1'b1;
    ID_NOP     = 1'b0;
    IFID_CLR   = 1'b0;

    if (MEM_BUSY) begin
      IF_LE      = 1'b0;
      ID_LE      = 1'b0;
      EX_LE      = 1'b0;
      MEM_LE     = 1'b0;
      state_next = FREEZE;
      if (BR_TAKEN) pend_next = 1'b1;
    end else if (BR_TAKEN) begin
      ID_NOP     = 1'b1;
      IFID_CLR   = 1'b1;
      flush_next = DEPTH_M1;
      state_next = (FLUSH_DEPTH > 1) ? FLUSH : RUN;
      pend_next  = 1'b0;
    end else if (state_reg == FLUSH) begin
      ID_NOP     = 1'b1;
      IFID_CLR   = 1'b1;
      flush_next = flush_reg - 1'b1;
      state_next = (flush_reg <= 1) ? RUN : FLUSH;
    end else begin
      // A branch deferred by a freeze starts its flush one cycle after release.
      if ((state_reg == FREEZE) && pend_reg) begin
        state_next = FLUSH;
        flush_next = DEPTH;
        pend_next  = 1'b0;
      end else begin
        state_next = RUN;
      end
      if (HAZ_NOP) begin
        IF_LE  = 1'b0;
        ID_LE  = 1'b0;
        ID_NOP = 1'b1;
      end
    end

    if (reset) begin
      IF_LE    = 1'b0;
      ID_LE    = 1'b0;
      EX_LE    = 1'b0;
      MEM_LE   = 1'b0;
      ID_NOP   = 1'b1;
      IFID_CLR = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
      flush_reg <= '0;
      pend_reg  <= 1'b0;
      MEM_TO    <= 1'b0;
    end else begin
      state_reg <= state_next;
      flush_reg <= flush_next;
      pend_reg  <= pend_next;
      if (MEM_BUSY && (wait_cnt >= TO_M1)) MEM_TO <= 1'b1;
    end
  end

  sat_counter #(.W(WAIT_W)) u_wait (
    .clk   (clk),
    .reset (reset),
    .clr   (~MEM_BUSY),
    .inc   (MEM_BUSY),
    .cnt   (wait_cnt)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic              stall_ev;
  logic [2:0]        perf_inc;
  logic [PERF_W-1:0] perf_cnt [3];

  assign stall_ev    = HAZ_NOP && !MEM_BUSY && !BR_TAKEN && (state_reg != FLUSH);
  assign perf_inc[0] = stall_ev;
  assign perf_inc[1] = BR_TAKEN;
  assign perf_inc[2] = MEM_BUSY;

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    sat_counter #(.W(PERF_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (PERF_CLR),
      .inc   (perf_inc[gi]),
      .cnt   (perf_cnt[gi])
    );
  end

  assign STALL_CNT  = perf_cnt[0];
  assign FLUSH_CNT  = perf_cnt[1];
  assign FREEZE_CNT = perf_cnt[2];
`else
  logic unused_perf_clr;
  assign unused_perf_clr = PERF_CLR;
  assign STALL_CNT  = '0;
  assign FLUSH_CNT  = '0;
  assign FREEZE_CNT = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (FLUSH_DEPTH=2, MEM_TIMEOUT=3).
module tb_pipeline_ctrl;

  localparam logic [5:0] IDLE  = 6'b1111_00;
  localparam logic [5:0] STALL = 6'b0011_10;
  localparam logic [5:0] FLSH  = 6'b1111_11;
  localparam logic [5:0] FRZ   = 6'b0000_00;
  localparam logic [5:0] RST   = 6'b0000_11;

  typedef struct {
    logic [5:0]  ctl;
    logic        to;
    logic        chk;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [15:0] zc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic haz = 1'b0, br = 1'b0, busy = 1'b0, pclr = 1'b0;
  logic if_le, id_le, ex_le, mem_le, id_nop, ifid_clr, mem_to;
  logic [15:0] stall_cnt, flush_cnt, freeze_cnt;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FLUSH_DEPTH(2), .MEM_TIMEOUT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .HAZ_NOP    (haz),
    .BR_TAKEN   (br),
    .MEM_BUSY   (busy),
    .PERF_CLR   (pclr),
    .IF_LE      (if_le),
    .ID_LE      (id_le),
    .EX_LE      (ex_le),
    .MEM_LE     (mem_le),
    .ID_NOP     (id_nop),
    .IFID_CLR   (ifid_clr),
    .MEM_TO     (mem_to),
    .STALL_CNT  (stall_cnt),
    .FLUSH_CNT  (flush_cnt),
    .FREEZE_CNT (freeze_cnt)
  );

  function automatic logic [15:0] pc(input logic [15:0] v);
`ifdef PIPE_CTRL_PERF_EN
    return v;
`else
    return 16'd0;
`endif
  endfunction

  // One cycle of stimulus plus the response expected in that same cycle.
  task automatic step(input logic r, input logic h, input logic b, input logic m,
                      input logic p, input logic [5:0] o, input logic to,
                      input logic chk = 1'b0, input logic [15:0] sc = 16'd0,
                      input logic [15:0] fc = 16'd0, input logic [15:0] zc = 16'd0);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; haz = h; br = b; busy = m; pclr = p;
    e.ctl = o; e.to = to; e.chk = chk; e.sc = sc; e.fc = fc; e.zc = zc;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] got;
      e = q.pop_front();
      got = {if_le, id_le, ex_le, mem_le, id_nop, ifid_clr};
      checks++;
      if (got !== e.ctl) begin
        failures++;
        $display("FAIL ctl t=%0t: got %b want %b (le,nop,clr)", $time, got, e.ctl);
      end
      checks++;
      if (mem_to !== e.to) begin
        failures++;
        $display("FAIL mem_to t=%0t: got %b want %b", $time, mem_to, e.to);
      end
      if (e.chk) begin
        checks++;
        if ({stall_cnt, flush_cnt, freeze_cnt} !== {e.sc, e.fc, e.zc}) begin
          failures++;
          $display("FAIL cnt t=%0t: got stall=%0d flush=%0d freeze=%0d want %0d %0d %0d",
                   $time, stall_cnt, flush_cnt, freeze_cnt, e.sc, e.fc, e.zc);
        end
      end
      $display("cyc t=%0t in r%b h%b b%b m%b p%b out %b to=%b", $time, reset, haz, br,
               busy, pclr, got, mem_to);
    end
  end

  initial begin
    // Reset held three cycles, then idle
    step(1, 0, 0, 0, 0, RST, 0);
    step(1, 0, 0, 0, 0, RST, 0);
    step(1, 0, 0, 0, 0, RST, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, IDLE, 0);
    step(0, 0, 0, 0, 0, IDLE, 0);
    // Single-cycle load-use stall
    step(0, 1, 0, 0, 0, STALL, 0);
    step(0, 0, 0, 0, 0, IDLE, 0, 1, pc(1), 0, 0);
    // Branch then HAZ_NOP inside the flush window, then a stall proves RUN
    step(0, 0, 1, 0, 0, FLSH, 0);
    step(0, 1, 0, 0, 0, FLSH, 0);
    step(0, 1, 0, 0, 0, STALL, 0);
    step(0, 0, 0, 0, 0, IDLE, 0, 1, pc(2), pc(1), 0);
    // Branch during FLUSH reloads the window
    step(0, 0, 1, 0, 0, FLSH, 0);
    step(0, 0, 1, 0, 0, FLSH, 0);
    step(0, 0, 0, 0, 0, FLSH, 0);
    step(0, 0, 0, 0, 0, IDLE, 0, 1, pc(2), pc(3), 0);
    // Freeze 4 cycles with a branch in the 2nd; flush starts after release
    step(0, 0, 0, 1, 0, FRZ, 0);
    step(0, 0, 1, 1, 0, FRZ, 0);
    step(0, 0, 0, 1, 0, FRZ, 0);
    step(0, 0, 0, 1, 0, FRZ, 1);
    step(0, 0, 0, 0, 0, IDLE, 1, 1, pc(2), pc(4), pc(4));
    step(0, 0, 0, 0, 0, FLSH, 1);
    step(0, 0, 0, 0, 0, FLSH, 1);
    step(0, 0, 0, 0, 0, IDLE, 1);
    // Reset mid-FLUSH discards the flush and clears MEM_TO
    step(0, 0, 1, 0, 0, FLSH, 1);
    step(1, 0, 0, 0, 0, RST, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, IDLE, 0);
    // Busy bursts shorter than the timeout with a gap do not set MEM_TO
    step(0, 0, 0, 1, 0, FRZ, 0);
    step(0, 0, 0, 1, 0, FRZ, 0);
    step(0, 0, 0, 0, 0, IDLE, 0);
    step(0, 0, 0, 1, 0, FRZ, 0);
    step(0, 0, 0, 1, 0, FRZ, 0);
    step(0, 0, 0, 0, 0, IDLE, 0);
    step(0, 0, 0, 0, 0, IDLE, 0);
    // Five busy cycles: MEM_TO rises after the 3rd and stays set
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, FRZ, (i >= 3) ? 1'b1 : 1'b0);
    step(0, 0, 0, 0, 0, IDLE, 1, 1, 0, 0, pc(9));
    step(0, 1, 0, 0, 0, STALL, 1);
    // PERF_CLR wins over a same-cycle increment
    step(0, 0, 0, 1, 1, FRZ, 1);
    step(0, 0, 0, 0, 0, IDLE, 1, 1, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
    // Saturation of FREEZE_CNT
    for (int i = 0; i < 65538; i++) step(0, 0, 0, 1, 0, FRZ, 1);
    step(0, 0, 0, 0, 0, IDLE, 1, 1, 0, 0, 16'hFFFF);
    step(0, 0, 0, 1, 1, FRZ, 1);
    step(0, 0, 0, 0, 0, IDLE, 1, 1, 0, 0, 0);
`endif
    @(posedge clk);
    #1;
    haz = 0; br = 0; busy = 0; pclr = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
